// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-side predictor paired with the program counter. It holds a
//   direct-mapped branch target buffer (BTB) with a 2-bit saturating direction
//   counter per entry.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     stall                 fetch stall; suppresses the lookup pulse
//     pc_count              current fetch PC, looked up every unstalled edge
//     resolve_*             execute-stage branch resolution (trains BTB and
//                           detects mispredicts)
//     pre_target(_enable)   predicted redirect; the enable is a one-cycle pulse
//     target(_enable)       corrective redirect on a mispredict (one-cycle pulse)
//     mispredict_count      saturating count of mispredicts
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      pc_count,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    input  logic             resolve_pred_taken,
    input  logic [31:0]      resolve_pred_target,
    output logic [31:0]      pre_target,
    output logic             pre_target_enable,
    output logic [31:0]      target,
    output logic             target_enable,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    // Saturating increment of a 2-bit direction counter
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        if (c == 2'b11) return 2'b11;
        else            return c + 2'b01;
    endfunction

    // Saturating decrement of a 2-bit direction counter
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        if (c == 2'b00) return 2'b00;
        else            return c - 2'b01;
    endfunction

    logic             valid_r [ENTRIES];
    logic [TAG_W-1:0] tag_r   [ENTRIES];
    logic [31:0]      tgt_r   [ENTRIES];
    logic [1:0]       cnt_r   [ENTRIES];

    logic [INDEX_BITS-1:0] lu_idx_s;
    logic [TAG_W-1:0]      lu_tag_s;
    logic                  lu_hit_s;
    logic                  predict_s;
    logic [INDEX_BITS-1:0] rs_idx_s;
    logic [TAG_W-1:0]      rs_tag_s;
    logic                  rs_hit_s;
    logic                  mispredict_s;
    logic [31:0]           correct_pc_s;
    logic                  unused_s;

    // The byte offset of the fetch PC plays no part in the lookup
    assign unused_s = ^pc_count[1:0];

    // Lookup and resolve decode; reads see pre-update BTB contents
    always_comb begin
        lu_idx_s     = pc_count[INDEX_BITS+1:2];
        lu_tag_s     = pc_count[31:INDEX_BITS+2];
        rs_idx_s     = resolve_pc[INDEX_BITS+1:2];
        rs_tag_s     = resolve_pc[31:INDEX_BITS+2];
        lu_hit_s     = valid_r[lu_idx_s] && (tag_r[lu_idx_s] == lu_tag_s);
        rs_hit_s     = valid_r[rs_idx_s] && (tag_r[rs_idx_s] == rs_tag_s);
        mispredict_s = 1'b0;
        if (resolve_valid) begin
            mispredict_s = (resolve_pred_taken != resolve_taken) ||
                           (resolve_taken && resolve_pred_taken &&
                            (resolve_pred_target != resolve_target));
        end else begin
            mispredict_s = 1'b0;
        end
        if (resolve_taken) correct_pc_s = resolve_target;
        else               correct_pc_s = resolve_pc + 32'd4;
        // A corrective redirect on this edge overrides any speculative one
        predict_s = lu_hit_s && cnt_r[lu_idx_s][1] && !stall && !mispredict_s;
    end

    // Redirect outputs and mispredict counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_target        <= 32'd0;
            pre_target_enable <= 1'b0;
            target            <= 32'd0;
            target_enable     <= 1'b0;
            mispredict_count  <= {CNT_W{1'b0}};
        end else begin
            pre_target_enable <= predict_s;
            if (predict_s) pre_target <= tgt_r[lu_idx_s];
            target_enable <= mispredict_s;
            if (mispredict_s) begin
                target <= correct_pc_s;
                if (mispredict_count != {CNT_W{1'b1}})
                    mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

    // BTB training from the resolve port, independent of stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= {TAG_W{1'b0}};
                tgt_r[i]   <= 32'd0;
                cnt_r[i]   <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (rs_hit_s) begin
                if (resolve_taken) begin
                    cnt_r[rs_idx_s] <= sat_inc(cnt_r[rs_idx_s]);
                    tgt_r[rs_idx_s] <= resolve_target;
                end else begin
                    cnt_r[rs_idx_s] <= sat_dec(cnt_r[rs_idx_s]);
                end
            end else if (resolve_taken) begin
                // Taken miss evicts whatever occupied this index
                valid_r[rs_idx_s] <= 1'b1;
                tag_r[rs_idx_s]   <= rs_tag_s;
                tgt_r[rs_idx_s]   <= resolve_target;
                cnt_r[rs_idx_s]   <= 2'b10;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side partner of the program counter: watches `pc_count` and drives the PC's `pre_target`/`pre_target_enable` (predicted redirect).
- Also drives `target`/`target_enable` (corrective redirect) when a resolved branch shows the prediction was wrong.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, updated from the execute-stage resolve port.

Parameters:
- INDEX_BITS, 4, log2 of BTB entries (16 entries).
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- stall  input  1  fetch stall; no lookup while 1
- pc_count  input  32  current PC from program counter
- resolve_valid  input  1  a branch resolved this cycle
- resolve_pc  input  32  PC of resolved branch
- resolve_taken  input  1  actual direction
- resolve_target  input  32  actual taken target
- resolve_pred_taken  input  1  prediction carried down the pipe with this branch
- resolve_pred_target  input  32  predicted target carried down the pipe
- pre_target  output  32  predicted next PC
- pre_target_enable  output  1  one-cycle pulse: load pre_target
- target  output  32  corrected PC
- target_enable  output  1  one-cycle pulse: load target (mispredict)
- mispredict_count  output  CNT_W  saturating count of mispredicts

Behaviour:
- Async reset (no clk edge required):
  - All BTB valid bits = 0, all counters = 2'b01.
  - `pre_target`, `target` = 0; both enables = 0; `mispredict_count` = 0.
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - pc[1:0] ignored.
- Lookup, at each posedge with `stall`==0:
  - hit = valid[idx] && tag match.
  - If hit and counter[idx] >= 2: `pre_target_enable` <= 1, `pre_target` <= btb_target[idx].
  - Otherwise `pre_target_enable` <= 0 and `pre_target` holds its value.
  - Latency: outputs reflect the `pc_count` sampled at the previous edge.
  - Enable is a single-cycle pulse; it never stays high two cycles for the same `pc_count` unless re-sampled.
- Stall: at a posedge with `stall`==1, `pre_target_enable` <= 0. BTB updates and mispredict logic still operate.
- Mispredict detect, on a posedge with `resolve_valid`==1:
  - mispredict = (resolve_pred_taken != resolve_taken) || (resolve_taken && resolve_pred_taken && resolve_pred_target != resolve_target).
  - On mispredict:
    - `target_enable` <= 1.
    - `target` <= resolve_taken ? resolve_target : resolve_pc + 4 (32-bit wrap).
    - `mispredict_count` += 1, saturating at all-ones.
  - Otherwise `target_enable` <= 0 and `target` holds.
- Priority: when `target_enable` is asserted at an edge, `pre_target_enable` is forced to 0 on that same edge. A corrective redirect always wins over a speculative one.
- BTB update, on `resolve_valid` (independent of `stall`):
  - Tag hit:
    - Counter: +1 if taken (sat 3), -1 if not taken (sat 0).
    - If taken, btb_target <= resolve_target.
  - Miss and taken: allocate (overwrite) the entry: valid=1, tag, target = resolve_target, counter = 2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: the lookup uses pre-update contents (read-before-write).
- Reset asserted mid-operation: clears immediately. A pending pulse is dropped and never completes after reset release.

Test Plan:
- Reset, then `pc_count`=0x40 with an empty BTB -> `pre_target_enable` stays 0 for 10 cycles; `mispredict_count`=0.
- Resolve pc=0x40 taken, target 0x100, pred_taken=0 -> next edge: `target_enable`=1 for one cycle, `target`=0x100, count=1, entry allocated with counter 2. Then drive `pc_count`=0x40 -> one cycle later `pre_target_enable`=1, `pre_target`=0x100.
- Same entry, two not-taken resolves with pred_taken=1 -> each gives `target`=0x44 pulse and count +1. Counter goes 2→1→0; a lookup of 0x40 then gives no prediction.
- Aliasing: 0x40 and 0x80 with INDEX_BITS=4 share an index (0x80 → index 0? check: 0x40[5:2]=0, 0x80[5:2]=0) but have different tags -> a lookup of 0x80 misses. A taken resolve of 0x80 evicts 0x40; a 0x40 lookup then misses.
- Simultaneous hit lookup and mispredict resolve on one edge -> `target_enable`=1, `pre_target_enable`=0. `stall`=1 with a hit PC -> no `pre_target_enable`, but a resolve during the stall still updates the BTB.
- Force 65535 mispredicts -> `mispredict_count`=0xFFFF holds on the next mispredict. Assert `reset` asynchronously mid-pulse -> all outputs 0 before the next clk edge.
